fixed_mac_accum: RTL and testbench

- Fixed-point multiply-accumulate stage that sits directly upstream of the fixed-point resize stage.
- Accepts a stream of signed operand pairs over a valid/ready handshake and forms full-precision products.
- Sums the products over a frame delimited by in_last.
- Presents the wide accumulated sum, sample count and overflow flag over a valid/ready output handshake. The resize stage narrows this result to the user format.

---
 rtl/fixed_pkg.sv | 24 ++
 rtl/fixed_mult_reg.sv | 56 +++++
 rtl/fixed_mac_accum.sv | 161 ++++++++++++++++
 tb/tb_fixed_mac_accum.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared types and width/overflow helpers for the fixed-point MAC stage.
package fixed_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  function automatic int prod_w(input int wi1, input int wf1, input int wi2, input int wf2);
    return wi1 + wf1 + wi2 + wf2;
  endfunction

  function automatic int acc_w(input int wi1, input int wf1, input int wi2, input int wf2,
                               input int guard);
    return prod_w(wi1, wf1, wi2, wf2) + guard;
  endfunction

  // Two's-complement add overflowed: like-signed addends gave a result of the other sign.
  function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_s);
    return (sign_a == sign_b) && (sign_s != sign_a);
  endfunction

endpackage

// File: rtl/fixed_mult_reg.sv
// Registered full-precision signed multiplier with valid/last sideband (MAC stage 1).
module fixed_mult_reg
  import fixed_pkg::*;
#(
  parameter int WI1 = 5,
  parameter int WF1 = 11,
  parameter int WI2 = 5,
  parameter int WF2 = 11
)(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_valid,
  input  logic [WI1+WF1-1:0]                  i_a,
  input  logic [WI2+WF2-1:0]                  i_b,
  input  logic                                i_last,
  output logic [prod_w(WI1,WF1,WI2,WF2)-1:0] o_prod,
  output logic                                o_valid,
  output logic                                o_last
);

  localparam int WA = WI1 + WF1;
  localparam int WB = WI2 + WF2;
  localparam int WP = prod_w(WI1, WF1, WI2, WF2);

  logic [WP-1:0] w_a_ext;
  logic [WP-1:0] w_b_ext;
  logic [WP-1:0] w_prod;
  logic [WP-1:0] r_prod;
  logic          r_valid;
  logic          r_last;

  // Operands are sign-extended to the product width so the low WP bits are the exact signed product.
  assign w_a_ext = {{(WP-WA){i_a[WA-1]}}, i_a};
  assign w_b_ext = {{(WP-WB){i_b[WB-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Product register; holds its value between accepted pairs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_prod <= w_prod;
        r_last <= i_last;
      end
    end
  end

  assign o_prod  = r_prod;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/fixed_mac_accum.sv
// Frame-based signed multiply-accumulate: sums full-precision products until in_last,
// then holds the wide sum, pair count and sticky overflow until downstream accepts.
module fixed_mac_accum
  import fixed_pkg::*;
#(
  parameter int WI1   = 5,
  parameter int WF1   = 11,
  parameter int WI2   = 5,
  parameter int WF2   = 11,
  parameter int GUARD = 4,
  parameter int LEN_W = 8
)(
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [WI1+WF1-1:0]                        in_a,
  input  logic [WI2+WF2-1:0]                        in_b,
  input  logic                                      in_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [acc_w(WI1,WF1,WI2,WF2,GUARD)-1:0]  out_data,
  output logic [LEN_W-1:0]                          out_count,
  output logic                                      out_ovf
);

  localparam int PW = prod_w(WI1, WF1, WI2, WF2);
  localparam int AW = acc_w(WI1, WF1, WI2, WF2, GUARD);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_accept;
  logic              w_handshake;
  logic [PW-1:0]     w_prod;
  logic              w_pv;
  logic              w_plast;
  logic [AW-1:0]     w_prod_ext;
  logic [AW-1:0]     w_sum;
  logic              w_ovf_step;
  logic [LEN_W-1:0]  w_count_inc;
  logic [AW-1:0]     r_acc;
  logic [LEN_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_out_valid;
  logic [AW-1:0]     r_out_data;
  logic [LEN_W-1:0]  r_out_count;
  logic              r_out_ovf;

  // Pairs are taken only while accumulating, and never while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      in_ready = 1'b0;
    end else if (r_state == ACCUM) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
  end

  assign w_accept    = in_valid & in_ready;
  assign w_handshake = r_out_valid & out_ready;

  fixed_mult_reg #(
    .WI1(WI1), .WF1(WF1), .WI2(WI2), .WF2(WF2)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_accept),
    .i_a     (in_a),
    .i_b     (in_b),
    .i_last  (in_last),
    .o_prod  (w_prod),
    .o_valid (w_pv),
    .o_last  (w_plast)
  );

  assign w_prod_ext  = {{GUARD{w_prod[PW-1]}}, w_prod};
  assign w_sum       = r_acc + w_prod_ext;
  assign w_ovf_step  = add_ovf(r_acc[AW-1], w_prod_ext[AW-1], w_sum[AW-1]);
  assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + LEN_W'(1);

  // Next-state logic for the accumulate / drain / output-hold sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ACCUM: begin
        if (w_accept && in_last) begin
          w_next_state = DRAIN;
        end else begin
          w_next_state = ACCUM;
        end
      end
      DRAIN: begin
        if (w_pv && w_plast) begin
          w_next_state = OUT;
        end else begin
          w_next_state = DRAIN;
        end
      end
      OUT: begin
        if (w_handshake) begin
          w_next_state = ACCUM;
        end else begin
          w_next_state = OUT;
        end
      end
      default: w_next_state = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Stage 2 accumulator; cleared once the frame result has been taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_handshake) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_pv) begin
      r_acc   <= w_sum;
      r_count <= w_count_inc;
      r_ovf   <= r_ovf | w_ovf_step;
    end
  end

  // Result register captures the sum including the final product, so it is ready at the OUT entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_pv && w_plast) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sum;
      r_out_count <= w_count_inc;
      r_out_ovf   <= r_ovf | w_ovf_step;
    end else if (w_handshake) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_fixed_mac_accum.sv
// Scoreboard bench for fixed_mac_accum: exact-integer frame model feeds a queue, a monitor checks results.
module tb_fixed_mac_accum;

  localparam int AW = 36;
  localparam int LW = 8;
  localparam longint LIM  = 64'sd34359738368;
  localparam longint SPAN = 64'sd68719476736;

  typedef struct {
    logic [AW-1:0] data;
    logic [LW-1:0] count;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a;
  logic [15:0]   in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic [LW-1:0] out_count;
  logic          out_ovf;

  exp_t   sb_q[$];
  longint frame_p[$];
  int     checks = 0;
  int     errors = 0;
  bit     stall_mode = 1'b0;
  int     stall_cnt = 0;

  always #5 clk = ~clk;

  fixed_mac_accum dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Exact mathematical sum, folded into the 36-bit two's-complement range; any fold is an overflow.
  function automatic exp_t model_frame();
    exp_t   e;
    longint s = 0;
    e.ovf = 1'b0;
    foreach (frame_p[i]) begin
      s = s + frame_p[i];
      if (s >= LIM) begin
        s = s - SPAN;
        e.ovf = 1'b1;
      end else if (s < -LIM) begin
        s = s + SPAN;
        e.ovf = 1'b1;
      end
    end
    e.data  = s[AW-1:0];
    e.count = (frame_p.size() > 255) ? 8'd255 : 8'(frame_p.size());
    return e;
  endfunction

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
    int t = 0;
    frame_p.push_back(longint'($signed(a)) * longint'($signed(b)));
    if (last) begin
      sb_q.push_back(model_frame());
      frame_p.delete();
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 500) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=no_accept required=accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: random, or a scripted 5-cycle stall on the next result.
  always @(posedge clk) begin
    #1;
    if (stall_mode) begin
      if (out_valid) begin
        if (stall_cnt < 5) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready  = 1'b1;
          stall_mode = 1'b0;
        end
      end else begin
        out_ready = 1'b0;
      end
    end else begin
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  int            cyc = 0;
  int            last_acc_cyc = -100;
  logic          p_ov = 1'b0;
  logic          p_or = 1'b0;
  logic [AW-1:0] p_data;
  logic [LW-1:0] p_count;
  logic          p_ovf;
  exp_t          got_e;

  // Monitor: protocol checks every cycle, scoreboard pop on each output handshake.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      p_ov = 1'b0;
      p_or = 1'b0;
    end else begin
      if (in_valid && in_ready && in_last) last_acc_cyc = cyc;
      if (cyc == last_acc_cyc + 1) chk("in_ready_drain", 64'(in_ready), 64'd0);
      if (out_valid && !p_ov) chk("latency", 64'(cyc - last_acc_cyc), 64'd2);
      if (out_valid) chk("in_ready_pending", 64'(in_ready), 64'd0);
      if (p_ov && !p_or) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(p_data));
        chk("stall_count", 64'(out_count), 64'(p_count));
        chk("stall_ovf", 64'(out_ovf), 64'(p_ovf));
      end
      if (p_ov && p_or) chk("ready_after_hs", 64'(in_ready), 64'd1);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h required=none", out_data);
        end else begin
          got_e = sb_q.pop_front();
          chk("data", 64'(out_data), 64'(got_e.data));
          chk("count", 64'(out_count), 64'(got_e.count));
          chk("ovf", 64'(out_ovf), 64'(got_e.ovf));
        end
      end
      p_ov    = out_valid;
      p_or    = out_ready;
      p_data  = out_data;
      p_count = out_count;
      p_ovf   = out_ovf;
    end
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          len;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_a     = 16'h0000;
    in_b     = 16'h0000;
    in_last  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // 1.0 * 1.0, single-pair frame
    send_pair(16'h0800, 16'h0800, 1'b1);
    // four of 1.5 * -2.0
    for (int i = 0; i < 4; i++) send_pair(16'h0C00, 16'hF000, i == 3);
    wait_drain();

    // same frame with bubbles and a 5-cycle output stall, then an immediate next frame
    stall_mode = 1'b1;
    stall_cnt  = 0;
    for (int i = 0; i < 4; i++) begin
      send_pair(16'h0C00, 16'hF000, i == 3);
      if (i < 3) idle(2);
    end
    send_pair(16'h0800, 16'h0800, 1'b1);
    wait_drain();

    // 32 full-scale negative squares wrap on the final add; next frame starts clean
    for (int i = 0; i < 32; i++) send_pair(16'h8000, 16'h8000, i == 31);
    send_pair(16'h0800, 16'h0800, 1'b1);
    // 16 full-scale products fit exactly in the guard bits
    for (int i = 0; i < 16; i++) send_pair(16'h8000, 16'h7FFF, i == 15);
    wait_drain();

    // reset in the middle of a frame
    for (int i = 0; i < 3; i++) send_pair(16'h0400, 16'h0C00, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    frame_p.delete();
    send_pair(16'h0800, 16'h0800, 1'b1);

    // randomized frames, some with extreme operands and bubbles
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          ra = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
          rb = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
        end else begin
          ra = 16'($urandom_range(0, 65535));
          rb = 16'($urandom_range(0, 65535));
        end
        send_pair(ra, rb, i == len - 1);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
    end

    // long frame exercising count saturation
    for (int i = 0; i < 260; i++) begin
      ra = 16'($urandom_range(0, 65535));
      send_pair(ra, 16'h0010, i == 259);
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
